// File: rtl/nseg_scroll_display.sv
// rtl/nseg_scroll_display.sv - N-digit multiplexed seven-segment driver with loadable scrolling message
//
// Ports:
//   clk      - single rising-edge clock
//   reset    - synchronous, active-high
//   button   - raw asynchronous push-button
//   mode     - 0: step per press, 1: auto-scroll with press toggling pause
//   wr_en    - message write strobe
//   wr_addr  - message write address (addresses >= MSG_LEN are ignored)
//   wr_data  - 4-bit character written into the message
//   an       - active-low anodes, an[NUM_DIGITS-1] is the leftmost digit
//   seg      - active-low segments {a,b,c,d,e,f,g}
//   dp       - decimal point, always off
//   ptr      - current scroll position (message index shown on the leftmost digit)
module nseg_scroll_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int MSG_LEN      = 16,
    parameter int DIGIT_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int SCROLL_DIV   = 500000,
    parameter int DEBOUNCE     = 16,
    localparam int AW = $clog2(MSG_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button,
    input  logic                  mode,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [AW-1:0]         ptr
);

    localparam int SW = $clog2(DIGIT_CYCLES);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(SCROLL_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    // ------------------------------------------------------------------
    // Button: two-flop synchroniser, then a stability counter. The
    // counter only runs while the synchronised sample disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    // ------------------------------------------------------------------
    logic          sync1_q, sync2_q;
    logic          db_q, db_prev_q;
    logic [CW-1:0] db_cnt_q;
    logic          press;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            if (sync2_q == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == CW'(DEBOUNCE - 1)) begin
                db_q     <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + CW'(1);
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Scroll control. The only FSM state is run/paused; the timer and
    // ptr are computed alongside it. A mode change takes priority over
    // everything else in its cycle and leaves ptr alone.
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } scroll_state_t;

    scroll_state_t state_q, state_d;
    logic          mode_q;
    logic          mode_chg;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] ptr_q, ptr_d;

    function automatic logic [AW-1:0] ptr_step(input logic [AW-1:0] p);
        return (p == AW'(MSG_LEN - 1)) ? '0 : p + AW'(1);
    endfunction

    assign mode_chg = mode ^ mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            mode_q  <= 1'b0;
            timer_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        if (mode_chg) begin
            state_d = ST_RUN;
            timer_d = '0;
        end else if (!mode) begin
            timer_d = '0;
            if (press) begin
                ptr_d = ptr_step(ptr_q);
            end
        end else if (press) begin
            // The press cycle itself only flips the pause flag.
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (timer_q == TW'(SCROLL_DIV - 1)) begin
                timer_d = '0;
                ptr_d   = ptr_step(ptr_q);
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Message memory. Reset restores the i mod 16 pattern.
    // ------------------------------------------------------------------
    logic [3:0] msg [MSG_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= 4'(i % 16);
            end
        end else if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN))) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Refresh: slot counter s, digit index d. The character for digit d
    // is sampled once at s==0, so writes or scrolls never disturb a slot
    // that is already being shown.
    // ------------------------------------------------------------------
    logic [SW-1:0] s_q;
    logic [DW-1:0] d_q;
    logic [6:0]    seg_q;
    logic [AW:0]   idx_sum;
    logic [AW-1:0] idx;
    logic [3:0]    char_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        logic [6:0] r;
        case (c)
            4'h0: r = 7'b0000001;
            4'h1: r = 7'b1001111;
            4'h2: r = 7'b0010010;
            4'h3: r = 7'b0000110;
            4'h4: r = 7'b1001100;
            4'h5: r = 7'b0100100;
            4'h6: r = 7'b0100000;
            4'h7: r = 7'b0001111;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0000100;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b1100000;
            4'hC: r = 7'b0110001;
            4'hD: r = 7'b1000010;
            4'hE: r = 7'b0110000;
            4'hF: r = 7'b0111000;
        endcase
        return r;
    endfunction

    // Digit d shows msg[(ptr + NUM_DIGITS-1-d) mod MSG_LEN]; the sum is
    // below 2*MSG_LEN so one conditional subtraction folds it back.
    always_comb begin
        idx_sum  = {1'b0, ptr_q} + (AW + 1)'(NUM_DIGITS - 1) - (AW + 1)'(d_q);
        idx      = AW'((idx_sum >= (AW + 1)'(MSG_LEN)) ? idx_sum - (AW + 1)'(MSG_LEN) : idx_sum);
        char_sel = msg[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= '0;
            d_q   <= '0;
            seg_q <= 7'b1111111;
        end else begin
            if (s_q == SW'(DIGIT_CYCLES - 1)) begin
                s_q <= '0;
                d_q <= (d_q == DW'(NUM_DIGITS - 1)) ? '0 : d_q + DW'(1);
            end else begin
                s_q <= s_q + SW'(1);
            end
            if (s_q == '0) begin
                seg_q <= seg_decode(char_sel);
            end
        end
    end

    // Anode guard bands at both ends of the slot keep the segment change
    // at s==1 and the digit hand-over well away from any lit anode.
    always_comb begin
        an = '1;
        if (({1'b0, s_q} >= (SW + 1)'(BLANK_CYCLES)) &&
            ({1'b0, s_q} <  (SW + 1)'(DIGIT_CYCLES - BLANK_CYCLES))) begin
            an[d_q] = 1'b0;
        end
    end

    assign seg = seg_q;
    assign dp  = 1'b1;
    assign ptr = ptr_q;

endmodule

// File: tb/tb_nseg_scroll_display.sv
// tb/tb_nseg_scroll_display.sv - self-checking bench for nseg_scroll_display
module tb_nseg_scroll_display;

    localparam int ND = 4;
    localparam int ML = 16;
    localparam int SD = 8;

    logic          clk = 1'b0;
    logic          reset, button, mode, wr_en, dp;
    logic [3:0]    wr_addr, wr_data, ptr;
    logic [ND-1:0] an;
    logic [6:0]    seg;

    nseg_scroll_display #(
        .NUM_DIGITS(ND), .MSG_LEN(ML), .DIGIT_CYCLES(16), .BLANK_CYCLES(2),
        .SCROLL_DIV(SD), .DEBOUNCE(16)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .an(an), .seg(seg), .dp(dp), .ptr(ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ch;
        logic [6:0] seg;
    } vec_t;

    vec_t       vecs [16];
    logic [3:0] msg_m [ML];
    int         ptr_m;
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [ND-1:0] an_low(input int d);
        logic [ND-1:0] m;
        m    = '1;
        m[d] = 1'b0;
        return m;
    endfunction

    // Expected anode pattern c cycles after reset release (slot 16, guard 2).
    function automatic logic [ND-1:0] an_exp(input int c);
        int s, d;
        s = c % 16;
        d = (c / 16) % ND;
        return (s >= 2 && s < 14) ? an_low(d) : '1;
    endfunction

    function automatic logic [6:0] win_seg(input int d);
        return vecs[msg_m[(ptr_m + ND - 1 - d) % ML]].seg;
    endfunction

    task automatic wait_an(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (an == an_low(d)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic press();
        button = 1'b1;
        tick(30);
        button = 1'b0;
        tick(30);
        if (!mode) ptr_m = (ptr_m + 1) % ML;
    endtask

    task automatic write(input logic [3:0] a, input logic [3:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        msg_m[a] = d;
    endtask

    task automatic check_window(input string name);
        bit ok;
        tick(70);
        check($sformatf("%s_ptr", name), int'(ptr), ptr_m);
        for (int d = 0; d < ND; d++) begin
            wait_an(d, ok);
            check($sformatf("%s_an%0d_seen", name, d), int'(ok), 1);
            if (ok) check($sformatf("%s_seg%0d", name, d), int'(seg), int'(win_seg(d)));
        end
    endtask

    // No more than one anode may ever be lit.
    always @(negedge clk) begin
        if ($countones(~an) > 1) begin
            total++;
            bad++;
            $display("FAIL onehot_an: got %b, expected at most one low", an);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [3:0] p, ra, rd;
        int         base;

        vecs[0]  = '{4'h0, 7'b0000001};  vecs[1]  = '{4'h1, 7'b1001111};
        vecs[2]  = '{4'h2, 7'b0010010};  vecs[3]  = '{4'h3, 7'b0000110};
        vecs[4]  = '{4'h4, 7'b1001100};  vecs[5]  = '{4'h5, 7'b0100100};
        vecs[6]  = '{4'h6, 7'b0100000};  vecs[7]  = '{4'h7, 7'b0001111};
        vecs[8]  = '{4'h8, 7'b0000000};  vecs[9]  = '{4'h9, 7'b0000100};
        vecs[10] = '{4'hA, 7'b0001000};  vecs[11] = '{4'hB, 7'b1100000};
        vecs[12] = '{4'hC, 7'b0110001};  vecs[13] = '{4'hD, 7'b1000010};
        vecs[14] = '{4'hE, 7'b0110000};  vecs[15] = '{4'hF, 7'b0111000};

        reset = 1'b1; button = 1'b0; mode = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < ML; i++) msg_m[i] = 4'(i);
        ptr_m = 0;
        tick(3);

        // Reset state
        check("rst_an",  int'(an),  'hF);
        check("rst_seg", int'(seg), 'h7F);
        check("rst_ptr", int'(ptr), 0);
        check("rst_dp",  int'(dp),  1);

        // T1: refresh pattern over one full frame
        reset = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("t1_an_c%0d", c), int'(an), int'(an_exp(c)));
            if (c % 16 >= 1) check($sformatf("t1_seg_c%0d", c), int'(seg), int'(win_seg((c / 16) % ND)));
            if (c == 8)  check("t1_right_msg3", int'(seg), int'(7'b0000110));
            if (c == 56) check("t1_left_msg0",  int'(seg), int'(7'b0000001));
        end

        // T2: bouncing button then a clean hold gives a single step
        for (int i = 0; i < 10; i++) begin
            button = 1'($urandom_range(0, 1));
            tick(1);
        end
        button = 1'b1;
        tick(40);
        button = 1'b0;
        tick(30);
        ptr_m = 1;
        check("t2_ptr", int'(ptr), 1);
        tick(70);
        wait_an(ND - 1, ok);
        check("t2_left_seen", int'(ok), 1);
        check("t2_left_seg", int'(seg), int'(7'b1001111));
        check_window("t2");

        // T3: clean presses up to and through the wrap
        for (int k = 0; k < 15; k++) begin
            press();
            check($sformatf("t3_ptr_%0d", k), int'(ptr), ptr_m);
            if (ptr_m == 14) begin
                tick(70);
                wait_an(0, ok);
                check("t3_right_seen", int'(ok), 1);
                check("t3_window_wrap", int'(seg), int'(7'b1001111));
            end
        end
        check("t3_wrapped", int'(ptr), 0);

        // Decode table through the leftmost digit
        for (int i = 0; i < 16; i++) begin
            write(4'(ptr_m), vecs[i].ch);
            tick(70);
            wait_an(ND - 1, ok);
            check($sformatf("dec_seen_%0d", i), int'(ok), 1);
            check($sformatf("dec_%0h", vecs[i].ch), int'(seg), int'(vecs[i].seg));
        end

        // Randomised writes and presses against the model
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 2) != 2) begin
                ra = 4'($urandom_range(0, ML - 1));
                rd = 4'($urandom_range(0, 15));
                write(ra, rd);
            end else begin
                press();
            end
            check_window($sformatf("rnd%0d", it));
        end

        // T5a: write during the leftmost slot does not alter that slot
        write(4'(ptr_m), 4'h0);
        tick(70);
        for (int i = 0; i < 100 && an == an_low(ND - 1); i++) @(negedge clk);
        wait_an(ND - 1, ok);
        check("t5_slot_seen", int'(ok), 1);
        wr_addr = 4'(ptr_m);
        wr_data = 4'hE;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        msg_m[ptr_m] = 4'hE;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_hold_an_%0d", i), int'(an), int'(an_low(ND - 1)));
            check($sformatf("t5_hold_seg_%0d", i), int'(seg), int'(7'b0000001));
            tick(1);
        end
        tick(70);
        wait_an(ND - 1, ok);
        check("t5_new_seen", int'(ok), 1);
        check("t5_new_seg", int'(seg), int'(7'b0110000));
        check_window("t5a");

        // T4 + T5b: auto-scroll every 8 clocks, with a write on a step edge
        base = ptr_m;
        ra   = 4'((ptr_m + 5) % ML);
        rd   = 4'($urandom_range(0, 15));
        mode = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            wr_en = 1'b0;
            check($sformatf("t4_ptr_k%0d", k), int'(ptr), (base + (k - 1) / SD) % ML);
            if (k == 16) begin
                wr_addr = ra;
                wr_data = rd;
                wr_en   = 1'b1;
            end
        end
        msg_m[ra] = rd;
        ptr_m = (base + 3) % ML;
        mode = 1'b0;
        check_window("t5b");

        // T4 pause/resume
        mode = 1'b1;
        tick(20);
        press();
        p = ptr;
        tick(40);
        check("t4_paused", int'(ptr), int'(p));
        press();
        check("t4_resumed", int'(ptr != p), 1);
        mode = 1'b0;
        tick(1);
        p = ptr;
        tick(40);
        check("t4_mode0_hold", int'(ptr), int'(p));

        // T6: reset mid-slot during auto-scroll
        mode = 1'b1;
        tick(30);
        wait_an(1, ok);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("t6_an",  int'(an),  'hF);
        check("t6_seg", int'(seg), 'h7F);
        check("t6_ptr", int'(ptr), 0);
        mode = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < ML; i++) msg_m[i] = 4'(i);
        ptr_m = 0;
        check_window("t6_w0");
        for (int g = 1; g < 4; g++) begin
            repeat (4) press();
            check_window($sformatf("t6_w%0d", g));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
